ahb_pixpos_writer: RTL
======================

Name: ahb_pixpos_writer

Overview:
- AHB-Lite bus master, the initiator counterpart to the pixel-position register slave.
- Accepts one (x, y, z) pixel-position triplet on a valid/ready interface.
- Issues three single-word NONSEQ write transfers to BASE_ADDR+0x0, +0x4 and +0x8.
- Lets hardware (sweep generator, test pattern engine) drive pixel positions without the Cortex-M0; sits as a second master ahead of the bus matrix.

Parameters:
- BASE_ADDR, 32'h5000_0000, byte address of the x register; y at +4, z at +8.

Ports:
- HCLK  in  1  bus clock
- HRESET  in  1  asynchronous reset, active-high
- HADDR  out  32  transfer address
- HTRANS  out  2  2'b10 NONSEQ or 2'b00 IDLE only
- HWRITE  out  1  1 during NONSEQ address phases, else 0
- HSIZE  out  3  fixed 3'b010 (word)
- HBURST  out  3  fixed 3'b000 (SINGLE)
- HWDATA  out  32  write data, data phase
- HREADY  in  1  transfer-complete / bus-ready from interconnect
- pos_valid  in  1  triplet available
- pos_ready  out  1  block accepts triplet this cycle
- pos_x, pos_y, pos_z  in  11 each  coordinates, sampled on handshake
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after z data phase completes

Behaviour:
- States: IDLE, AX (addr x), AY (addr y / data x), AZ (addr z / data y), DZ (data z).
- Handshake fires when pos_valid & pos_ready; triplet is captured into holding registers x_r, y_r, z_r on that edge.
- pos_ready = (state==IDLE) | (state==DZ & HREADY). This is the only combinational input-to-output path.
- Transitions on the rising edge of HCLK:
  - IDLE -> AX on handshake.
  - AX -> AY, AY -> AZ and AZ -> DZ, each only when HREADY=1.
  - DZ -> AX if HREADY & handshake; DZ -> IDLE if HREADY & no handshake.
  - Any state with HREADY=0 holds.
- Outputs by state (HADDR, HTRANS/HWRITE, HWDATA):
  - IDLE: BASE_ADDR, IDLE/0, last driven value.
  - AX: BASE_ADDR, NONSEQ/1, last driven value.
  - AY: BASE_ADDR+4, NONSEQ/1, {21'b0, x_r}.
  - AZ: BASE_ADDR+8, NONSEQ/1, {21'b0, y_r}.
  - DZ: BASE_ADDR+8, IDLE/0, {21'b0, z_r}.
- All bus outputs are driven from registers. HADDR, HTRANS and HWDATA stay stable through every HREADY=0 cycle, as AHB-Lite requires.
- Data is zero-extended from 11 to 32 bits; there is no sign extension or truncation.
- done is registered. It is high for exactly one cycle, the cycle after the DZ cycle in which HREADY=1.
- Throughput with no wait states: 4 cycles per triplet, including one HTRANS=IDLE slot (DZ) between triplets.
- HRESET asserted (asynchronous, any state): state=IDLE, HADDR=BASE_ADDR, HTRANS=00, HWRITE=0, HWDATA=0, x_r/y_r/z_r=0, done=0, busy=0.
  - An in-flight triplet is dropped and no done is generated.
  - pos_ready=1 in the first cycle after reset is released.
- No HRESP input; error responses are not handled.

Decomposition:
- Shared package holds:
  - state enum {IDLE, AX, AY, AZ, DZ};
  - HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10;
  - HSIZE_WORD=3'b010, HBURST_SINGLE=3'b000;
  - register offsets OFF_X=0x0, OFF_Y=0x4, OFF_Z=0x8, shared with the slave.
- Single module; no sub-module is natural.

Test Plan:
- Reset: HRESET=1 for 3 cycles then 0 -> during reset HTRANS=00, HADDR=32'h5000_0000, HWDATA=0, done=0; after release pos_ready=1.
- Single triplet (100, 200, 3), HREADY=1 throughout, handshake at cycle 0 ->
  - c1: HADDR=5000_0000, NONSEQ, HWRITE=1;
  - c2: HADDR=5000_0004, HWDATA=100;
  - c3: HADDR=5000_0008, HWDATA=200;
  - c4: HTRANS=00, HWDATA=3;
  - c5: done=1, busy=0.
- Wait states: HREADY=0 for 2 cycles while in AY -> HADDR=5000_0004 and HWDATA=100 held for 3 cycles; done arrives at c7.
- Back-to-back triplets (1,2,3) then (4,5,6), pos_valid held high -> second handshake in the DZ cycle c4; HADDR=5000_0000 NONSEQ at c5; HWDATA=4 at c6; exactly one done for each triplet, at c5 and c9.
- Asynchronous reset asserted mid-cycle during AZ -> HTRANS=00 immediately, no done pulse; the next triplet (7,8,9) starts again at HADDR=5000_0000.
- Width check: pos_x=11'h7FF, pos_y=0, pos_z=11'h400 -> HWDATA sequence 0000_07FF, 0000_0000, 0000_0400.

Source files
------------

// File: rtl/ahb_pixpos_writer_pkg.sv
// Shared definitions for the pixel-position AHB-Lite writer and its register-slave counterpart.
// Holds the FSM states, the AHB encodings and the register offsets.
package ahb_pixpos_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AX   = 3'd1,
    ST_AY   = 3'd2,
    ST_AZ   = 3'd3,
    ST_DZ   = 3'd4
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [31:0] OFF_X = 32'h0000_0000;
  localparam logic [31:0] OFF_Y = 32'h0000_0004;
  localparam logic [31:0] OFF_Z = 32'h0000_0008;

  function automatic logic [31:0] zext11(input logic [10:0] v);
    return {21'd0, v};
  endfunction

endpackage

// File: rtl/ahb_pixpos_writer.sv
// AHB-Lite master that writes one (x, y, z) pixel-position triplet as three
// single-word NONSEQ writes to BASE_ADDR+0x0/+0x4/+0x8.
module ahb_pixpos_writer
  import ahb_pixpos_writer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h5000_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        pos_valid,
  output logic        pos_ready,
  input  logic [10:0] pos_x,
  input  logic [10:0] pos_y,
  input  logic [10:0] pos_z,
  output logic        busy,
  output logic        done
);

  state_e      state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        hs_s;

  // A new triplet may be taken when idle or while the z data phase completes.
  assign pos_ready = (state_q == ST_IDLE) || ((state_q == ST_DZ) && HREADY);
  assign hs_s      = pos_valid && pos_ready;

  // Next-state logic; every bus-facing state holds while HREADY is low.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hs_s)   state_d = ST_AX; else state_d = ST_IDLE;
      ST_AX:   if (HREADY) state_d = ST_AY; else state_d = ST_AX;
      ST_AY:   if (HREADY) state_d = ST_AZ; else state_d = ST_AY;
      ST_AZ:   if (HREADY) state_d = ST_DZ; else state_d = ST_AZ;
      ST_DZ: begin
        if (HREADY) state_d = hs_s ? ST_AX : ST_IDLE;
        else        state_d = ST_DZ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they leave the block registered.
  always_comb begin
    haddr_d  = BASE_ADDR + OFF_X;
    htrans_d = HTRANS_IDLE;
    hwrite_d = 1'b0;
    hwdata_d = hwdata_q;
    case (state_d)
      ST_IDLE: begin
        haddr_d = BASE_ADDR + OFF_X;
      end
      ST_AX: begin
        haddr_d  = BASE_ADDR + OFF_X;
        htrans_d = HTRANS_NONSEQ;
        hwrite_d = 1'b1;
      end
      ST_AY: begin
        haddr_d  = BASE_ADDR + OFF_Y;
        htrans_d = HTRANS_NONSEQ;
        hwrite_d = 1'b1;
        hwdata_d = zext11(x_q);
      end
      ST_AZ: begin
        haddr_d  = BASE_ADDR + OFF_Z;
        htrans_d = HTRANS_NONSEQ;
        hwrite_d = 1'b1;
        hwdata_d = zext11(y_q);
      end
      ST_DZ: begin
        haddr_d  = BASE_ADDR + OFF_Z;
        hwdata_d = zext11(z_q);
      end
      default: begin
        haddr_d = BASE_ADDR + OFF_X;
      end
    endcase
  end

  // Triplet capture, completion pulse and busy flag.
  always_comb begin
    x_d    = hs_s ? pos_x : x_q;
    y_d    = hs_s ? pos_y : y_q;
    z_d    = hs_s ? pos_z : z_q;
    done_d = (state_q == ST_DZ) && HREADY;
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any in-flight triplet.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      haddr_q  <= BASE_ADDR + OFF_X;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
      hwdata_q <= 32'd0;
      x_q      <= 11'd0;
      y_q      <= 11'd0;
      z_q      <= 11'd0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign HADDR  = haddr_q;
  assign HTRANS = htrans_q;
  assign HWRITE = hwrite_q;
  assign HWDATA = hwdata_q;
  assign HSIZE  = HSIZE_WORD;
  assign HBURST = HBURST_SINGLE;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule
